axi4lite_master: RTL and testbench

AXI4LITE_MASTER -- requirements
Module: axi4lite_master

---
 rtl/axi4lite_master.sv | 188 ++++++++++++++++++
 tb/tb_axi4lite_master.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_master.sv
// ---------------------------------------------------------------------------
// axi4lite_master
// Single-beat AXI4-Lite master that turns pipeline load/store requests into
// AXI4-Lite transactions. The write and read paths are independent FSMs, so
// a load and a store may be in flight together.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   write_start/addr/data/strobe  store request (level, held while stalled)
//   write_busy                 stall request while a store is in progress
//   read_start/addr            load request (level, held while stalled)
//   read_data                  registered word from the last R handshake
//   read_busy                  stall request while a load is in progress
//   bus_error                  sticky: any non-OKAY BRESP/RRESP seen
//   m_axi_aw*/w*/b*/ar*/r*     AXI4-Lite master channels
// ---------------------------------------------------------------------------
module axi4lite_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    write_start,
   input  logic [ADDR_WIDTH-1:0]   write_addr,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic [DATA_WIDTH/8-1:0] write_strobe,
   output logic                    write_busy,
   input  logic                    read_start,
   input  logic [ADDR_WIDTH-1:0]   read_addr,
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    read_busy,
   output logic                    bus_error,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_DONE} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   // aw_done/w_done record which half of the write request has already
   // handshaken, so each valid drops on its own ready.
   logic                    aw_done, w_done, aw_done_nxt, w_done_nxt;
   logic                    latch_w, latch_r, capture_r;
   logic                    wr_err, rd_err;
   logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] wstrb_q;

   assign m_axi_awaddr = awaddr_q;
   assign m_axi_wdata  = wdata_q;
   assign m_axi_wstrb  = wstrb_q;
   assign m_axi_araddr = araddr_q;

   // ---------------- write path ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state  <= W_IDLE;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
      end else begin
         w_state <= w_next;
         aw_done <= aw_done_nxt;
         w_done  <= w_done_nxt;
         if (latch_w) begin
            awaddr_q <= write_addr;
            wdata_q  <= write_data;
            wstrb_q  <= write_strobe;
         end
      end
   end

   always_comb begin
      w_next        = w_state;
      aw_done_nxt   = aw_done;
      w_done_nxt    = w_done;
      latch_w       = 1'b0;
      wr_err        = 1'b0;
      write_busy    = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      case (w_state)
         W_IDLE: begin
            write_busy = write_start;
            if (write_start) begin
               latch_w     = 1'b1;
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
               w_next      = W_REQ;
            end
         end
         W_REQ: begin
            write_busy    = 1'b1;
            m_axi_awvalid = !aw_done;
            m_axi_wvalid  = !w_done;
            if (!aw_done && m_axi_awready) aw_done_nxt = 1'b1;
            if (!w_done && m_axi_wready)   w_done_nxt  = 1'b1;
            if (aw_done_nxt && w_done_nxt) w_next = W_RESP;
         end
         W_RESP: begin
            write_busy   = 1'b1;
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               wr_err = (m_axi_bresp != 2'b00);
               w_next = W_DONE;
            end
         end
         W_DONE:  w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // ---------------- read path ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= R_IDLE;
         araddr_q  <= '0;
         read_data <= '0;
      end else begin
         r_state <= r_next;
         if (latch_r)   araddr_q  <= read_addr;
         if (capture_r) read_data <= m_axi_rdata;
      end
   end

   always_comb begin
      r_next        = r_state;
      latch_r       = 1'b0;
      capture_r     = 1'b0;
      rd_err        = 1'b0;
      read_busy     = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      case (r_state)
         R_IDLE: begin
            read_busy = read_start;
            if (read_start) begin
               latch_r = 1'b1;
               r_next  = R_ADDR;
            end
         end
         R_ADDR: begin
            read_busy     = 1'b1;
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) r_next = R_DATA;
         end
         R_DATA: begin
            read_busy    = 1'b1;
            m_axi_rready = 1'b1;
            if (m_axi_rvalid) begin
               capture_r = 1'b1;
               rd_err    = (m_axi_rresp != 2'b00);
               r_next    = R_DONE;
            end
         end
         R_DONE:  r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // ---------------- sticky error ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               bus_error <= 1'b0;
      else if (wr_err || rd_err) bus_error <= 1'b1;
   end

endmodule

// File: tb/tb_axi4lite_master.sv
module tb_axi4lite_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        write_start, read_start;
   logic [31:0] write_addr, write_data, read_addr;
   logic [3:0]  write_strobe;
   logic        write_busy, read_busy, bus_error;
   logic [31:0] read_data;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [1:0]  m_axi_bresp, m_axi_rresp;
   logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rvalid, m_axi_rready;

   always #5 clk = ~clk;

   axi4lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .write_start(write_start), .write_addr(write_addr), .write_data(write_data),
      .write_strobe(write_strobe), .write_busy(write_busy),
      .read_start(read_start), .read_addr(read_addr), .read_data(read_data),
      .read_busy(read_busy), .bus_error(bus_error),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // slave behaviour knobs
   int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   logic [31:0] rdata_cfg = '0;
   logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
   bit          stray_b = 1'b0, stray_r = 1'b0;

   // handshakes that occur at the coming rising edge (sampled on falling edge)
   bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
   int aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, r_hs_cnt = 0;

   // scoreboard
   logic [31:0] aw_exp[$];
   logic [35:0] w_exp[$];
   logic [31:0] ar_exp[$];
   logic [31:0] r_exp[$];

   // ---------------- monitor / scoreboard compare ----------------
   initial begin
      logic [31:0] e32;
      logic [35:0] e36;
      forever begin
         @(negedge clk);
         aw_hs = m_axi_awvalid & m_axi_awready;
         w_hs  = m_axi_wvalid  & m_axi_wready;
         b_hs  = m_axi_bvalid  & m_axi_bready;
         ar_hs = m_axi_arvalid & m_axi_arready;
         r_hs  = m_axi_rvalid  & m_axi_rready;
         if (b_hs) b_hs_cnt++;
         if (r_hs) r_hs_cnt++;
         if (aw_hs) begin
            aw_hs_cnt++;
            n_checks++;
            if (aw_exp.size() == 0) begin
               n_fail++;
               $display("FAIL aw_sb: unexpected AW handshake addr=%h, required none", m_axi_awaddr);
            end else begin
               e32 = aw_exp.pop_front();
               if (m_axi_awaddr !== e32) begin
                  n_fail++;
                  $display("FAIL aw_sb: awaddr=%h, required %h", m_axi_awaddr, e32);
               end
            end
         end
         if (w_hs) begin
            w_hs_cnt++;
            n_checks++;
            if (w_exp.size() == 0) begin
               n_fail++;
               $display("FAIL w_sb: unexpected W handshake data=%h, required none", m_axi_wdata);
            end else begin
               e36 = w_exp.pop_front();
               if ({m_axi_wstrb, m_axi_wdata} !== e36) begin
                  n_fail++;
                  $display("FAIL w_sb: strb/data=%h, required %h", {m_axi_wstrb, m_axi_wdata}, e36);
               end
            end
         end
         if (ar_hs) begin
            ar_hs_cnt++;
            n_checks++;
            if (ar_exp.size() == 0) begin
               n_fail++;
               $display("FAIL ar_sb: unexpected AR handshake addr=%h, required none", m_axi_araddr);
            end else begin
               e32 = ar_exp.pop_front();
               if (m_axi_araddr !== e32) begin
                  n_fail++;
                  $display("FAIL ar_sb: araddr=%h, required %h", m_axi_araddr, e32);
               end
            end
         end
      end
   end

   // ---------------- slave model ----------------
   initial begin
      bit bvalid_s, rvalid_s, aw_got, w_got, b_wait, r_wait;
      int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
      bvalid_s = 0; rvalid_s = 0; aw_got = 0; w_got = 0; b_wait = 0; r_wait = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            bvalid_s = 0; rvalid_s = 0; aw_got = 0; w_got = 0; b_wait = 0; r_wait = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
         end else begin
            if (aw_hs) aw_got = 1;
            if (w_hs)  w_got  = 1;
            if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_wait = 1; b_cnt = 0; end
            if (b_hs) begin bvalid_s = 0; b_wait = 0; end
            if (b_wait && !bvalid_s) begin
               if (b_cnt >= b_delay) bvalid_s = 1; else b_cnt++;
            end
            if (ar_hs) begin r_wait = 1; r_cnt = 0; end
            if (r_hs)  begin rvalid_s = 0; r_wait = 0; end
            if (r_wait && !rvalid_s) begin
               if (r_cnt >= r_delay) rvalid_s = 1; else r_cnt++;
            end
            if (m_axi_awvalid) begin
               if (aw_cnt >= aw_delay) m_axi_awready = 1; else begin m_axi_awready = 0; aw_cnt++; end
            end else begin m_axi_awready = 0; aw_cnt = 0; end
            if (m_axi_wvalid) begin
               if (w_cnt >= w_delay) m_axi_wready = 1; else begin m_axi_wready = 0; w_cnt++; end
            end else begin m_axi_wready = 0; w_cnt = 0; end
            if (m_axi_arvalid) begin
               if (ar_cnt >= ar_delay) m_axi_arready = 1; else begin m_axi_arready = 0; ar_cnt++; end
            end else begin m_axi_arready = 0; ar_cnt = 0; end
         end
         m_axi_bvalid = bvalid_s | stray_b;
         m_axi_bresp  = stray_b ? 2'b10 : bresp_cfg;
         m_axi_rvalid = rvalid_s | stray_r;
         m_axi_rresp  = stray_r ? 2'b10 : rresp_cfg;
         m_axi_rdata  = stray_r ? 32'hBAD0_BAD0 : rdata_cfg;
      end
   end

   // ---------------- stimulus drivers ----------------
   task automatic run_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit hold, output int busy, output bit to);
      @(posedge clk);
      #1;
      write_start = 1; write_addr = a; write_data = d; write_strobe = s;
      aw_exp.push_back(a);
      w_exp.push_back({s, d});
      busy = 0;
      to   = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (write_busy) busy++;
         else begin to = 0; break; end
      end
      if (!hold) begin
         @(posedge clk);
         #1;
         write_start = 0;
      end
   endtask

   task automatic run_read(input logic [31:0] a, output int busy, output bit to,
                           output logic [31:0] rd);
      @(posedge clk);
      #1;
      read_start = 1; read_addr = a;
      ar_exp.push_back(a);
      r_exp.push_back(rdata_cfg);
      busy = 0;
      to   = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (read_busy) busy++;
         else begin to = 0; break; end
      end
      rd = read_data;
      @(posedge clk);
      #1;
      read_start = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 0;
      write_start = 0; read_start = 0;
      write_addr = '0; write_data = '0; write_strobe = '0; read_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_handshake: aw/w/b/ar/r=%b, required 00000",
                  {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
      end
      n_checks++;
      if ({read_data, bus_error} !== 33'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: read_data=%h bus_error=%b, required 0/0", read_data, bus_error);
      end
      n_checks++;
      if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_araddr} !== 100'd0) begin
         n_fail++;
         $display("FAIL reset_payload: awaddr=%h wdata=%h wstrb=%h araddr=%h, required 0",
                  m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_araddr);
      end
      @(posedge clk);
      #1;
      rst_n = 1;
      @(negedge clk);
      n_checks++;
      if ({write_busy, read_busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_busy: busy w/r=%b, required 00", {write_busy, read_busy});
      end
   endtask

   task automatic test_stray_response();
      int b0;
      b0 = b_hs_cnt;
      @(posedge clk);
      #1;
      stray_b = 1; stray_r = 1;
      repeat (3) @(posedge clk);
      #1;
      stray_b = 0; stray_r = 0;
      @(negedge clk);
      n_checks++;
      if (bus_error !== 1'b0) begin
         n_fail++;
         $display("FAIL stray_error: bus_error=%b, required 0", bus_error);
      end
      n_checks++;
      if (read_data !== 32'd0) begin
         n_fail++;
         $display("FAIL stray_rdata: read_data=%h, required 00000000", read_data);
      end
      n_checks++;
      if (b_hs_cnt - b0 !== 0) begin
         n_fail++;
         $display("FAIL stray_bhs: B handshakes=%0d, required 0", b_hs_cnt - b0);
      end
   endtask

   task automatic test_basic_write();
      int busy, a0, b0;
      bit to;
      aw_delay = 0; w_delay = 0; b_delay = 0;
      a0 = aw_hs_cnt; b0 = b_hs_cnt;
      run_write(32'h100, 32'hDEAD_BEEF, 4'hF, 0, busy, to);
      n_checks++;
      if (to !== 1'b0 || busy !== 3) begin
         n_fail++;
         $display("FAIL basic_write_busy: busy=%0d timeout=%b, required 3/0", busy, to);
      end
      n_checks++;
      if (aw_hs_cnt - a0 !== 1 || b_hs_cnt - b0 !== 1) begin
         n_fail++;
         $display("FAIL basic_write_hs: aw=%0d b=%0d, required 1/1", aw_hs_cnt - a0, b_hs_cnt - b0);
      end
      n_checks++;
      if (bus_error !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_write_err: bus_error=%b, required 0", bus_error);
      end
   endtask

   task automatic test_delayed_write();
      int busy, a0, w0, b0;
      bit to;
      aw_delay = 0; w_delay = 2; b_delay = 3;
      a0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
      run_write(32'h0000_0104, 32'h0BAD_CAFE, 4'b0110, 0, busy, to);
      // start + (1+max(aw,w) delay) REQ cycles + (1+b delay) RESP cycles
      n_checks++;
      if (to !== 1'b0 || busy !== 8) begin
         n_fail++;
         $display("FAIL delayed_write_busy: busy=%0d timeout=%b, required 8/0", busy, to);
      end
      n_checks++;
      if (aw_hs_cnt - a0 !== 1 || w_hs_cnt - w0 !== 1 || b_hs_cnt - b0 !== 1) begin
         n_fail++;
         $display("FAIL delayed_write_hs: aw=%0d w=%0d b=%0d, required 1/1/1",
                  aw_hs_cnt - a0, w_hs_cnt - w0, b_hs_cnt - b0);
      end
      aw_delay = 0; w_delay = 0; b_delay = 0;
   endtask

   task automatic test_read();
      int busy;
      bit to;
      logic [31:0] rd, e;
      ar_delay = 4; r_delay = 0;
      rdata_cfg = 32'h1234_5678;
      run_read(32'h200, busy, to, rd);
      n_checks++;
      if (to !== 1'b0 || busy !== 7) begin
         n_fail++;
         $display("FAIL read_busy: busy=%0d timeout=%b, required 7/0", busy, to);
      end
      e = r_exp.pop_front();
      n_checks++;
      if (rd !== e) begin
         n_fail++;
         $display("FAIL read_data_done: read_data=%h, required %h", rd, e);
      end
      rdata_cfg = 32'h0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (read_data !== e || read_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL read_data_hold: read_data=%h busy=%b, required %h/0", read_data, read_busy, e);
      end
      ar_delay = 0;
   endtask

   task automatic test_read_error();
      int busy;
      bit to;
      logic [31:0] rd, e;
      rdata_cfg = 32'hCAFE_F00D; rresp_cfg = 2'b10;
      run_read(32'h300, busy, to, rd);
      e = r_exp.pop_front();
      n_checks++;
      if (to !== 1'b0 || rd !== e || bus_error !== 1'b1) begin
         n_fail++;
         $display("FAIL read_error: data=%h err=%b timeout=%b, required %h/1/0", rd, bus_error, to, e);
      end
      rresp_cfg = 2'b00; rdata_cfg = 32'h5555_AAAA;
      run_write(32'h108, 32'h0000_0001, 4'h1, 0, busy, to);
      run_read(32'h304, busy, to, rd);
      e = r_exp.pop_front();
      n_checks++;
      if (rd !== e) begin
         n_fail++;
         $display("FAIL read_ok_after_err: read_data=%h, required %h", rd, e);
      end
      n_checks++;
      if (bus_error !== 1'b1) begin
         n_fail++;
         $display("FAIL error_sticky: bus_error=%b, required 1", bus_error);
      end
   endtask

   task automatic test_simultaneous();
      bit done;
      logic [31:0] e;
      rdata_cfg = 32'h0F0F_1234;
      @(posedge clk);
      #1;
      write_start = 1; write_addr = 32'h140; write_data = 32'h7777_8888; write_strobe = 4'hF;
      read_start  = 1; read_addr  = 32'h240;
      aw_exp.push_back(32'h140);
      w_exp.push_back({4'hF, 32'h7777_8888});
      ar_exp.push_back(32'h240);
      r_exp.push_back(32'h0F0F_1234);
      @(negedge clk);
      n_checks++;
      if ({write_busy, read_busy} !== 2'b11) begin
         n_fail++;
         $display("FAIL simul_busy: busy w/r=%b, required 11", {write_busy, read_busy});
      end
      @(negedge clk);
      n_checks++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid} !== 3'b111) begin
         n_fail++;
         $display("FAIL simul_valid: aw/w/ar=%b, required 111",
                  {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid});
      end
      done = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!write_busy || !read_busy) begin done = 1; break; end
      end
      n_checks++;
      if (!done || {write_busy, read_busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL simul_done: busy w/r=%b finished=%b, required 00/1", {write_busy, read_busy}, done);
      end
      e = r_exp.pop_front();
      n_checks++;
      if (read_data !== e) begin
         n_fail++;
         $display("FAIL simul_rdata: read_data=%h, required %h", read_data, e);
      end
      @(posedge clk);
      #1;
      write_start = 0; read_start = 0;
   endtask

   task automatic test_reset_mid();
      int busy, a0;
      bit to, seen;
      aw_delay = 10; w_delay = 10;
      @(posedge clk);
      #1;
      write_start = 1; write_addr = 32'h400; write_data = 32'h1357_9BDF; write_strobe = 4'hF;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (m_axi_awvalid) begin seen = 1; break; end
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL midreset_awvalid: awvalid never rose, required 1");
      end
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      n_checks++;
      if ({m_axi_awvalid, m_axi_wvalid} !== 2'b00) begin
         n_fail++;
         $display("FAIL midreset_valid: aw/w valid=%b, required 00", {m_axi_awvalid, m_axi_wvalid});
      end
      n_checks++;
      if ({bus_error, read_data, m_axi_awaddr} !== 65'd0) begin
         n_fail++;
         $display("FAIL midreset_state: err=%b rdata=%h awaddr=%h, required 0",
                  bus_error, read_data, m_axi_awaddr);
      end
      write_start = 0;
      aw_delay = 0; w_delay = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      a0 = aw_hs_cnt;
      run_write(32'h500, 32'hA5A5_5A5A, 4'b0011, 0, busy, to);
      n_checks++;
      if (to !== 1'b0 || busy !== 3 || aw_hs_cnt - a0 !== 1) begin
         n_fail++;
         $display("FAIL midreset_clean: busy=%0d aw=%0d timeout=%b, required 3/1/0",
                  busy, aw_hs_cnt - a0, to);
      end
   endtask

   task automatic test_back_to_back();
      int busy1, busy2, a0, b0;
      bit to1, to2;
      a0 = aw_hs_cnt; b0 = b_hs_cnt;
      run_write(32'h600, 32'h1111_1111, 4'hF, 1, busy1, to1);
      run_write(32'h604, 32'h2222_2222, 4'hC, 0, busy2, to2);
      repeat (5) @(negedge clk);
      n_checks++;
      if (to1 || to2 || busy1 !== 3 || busy2 !== 3) begin
         n_fail++;
         $display("FAIL b2b_busy: busy=%0d/%0d timeout=%b/%b, required 3/3 0/0", busy1, busy2, to1, to2);
      end
      n_checks++;
      if (aw_hs_cnt - a0 !== 2 || b_hs_cnt - b0 !== 2 || m_axi_awvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_count: aw=%0d b=%0d awvalid=%b, required 2/2/0",
                  aw_hs_cnt - a0, b_hs_cnt - b0, m_axi_awvalid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stray_response();
      test_basic_write();
      test_delayed_write();
      test_read();
      test_read_error();
      test_simultaneous();
      test_reset_mid();
      test_back_to_back();
      n_checks++;
      if (aw_exp.size() != 0 || w_exp.size() != 0 || ar_exp.size() != 0 || r_exp.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: left aw=%0d w=%0d ar=%0d r=%0d, required 0",
                  aw_exp.size(), w_exp.size(), ar_exp.size(), r_exp.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
